// File: rtl/store_buffer_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : store_buffer_pkg
// Brief  : Shared constants and entry type for the store buffer.
// Rev    : 1.0
// ---------------------------------------------------------------------------
package store_buffer_pkg;

    localparam logic [31:0] c_word_zero = 32'h0000_0000;
    localparam int          c_sb_depth  = 4;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } sb_entry_t;

endpackage
`default_nettype wire

// File: rtl/store_buffer_match.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : store_buffer_match
// Brief  : Youngest-first address match over the valid store buffer entries.
// Rev    : 1.0
// ---------------------------------------------------------------------------
module store_buffer_match
    import store_buffer_pkg::*;
#(
    parameter int DEPTH = c_sb_depth,
    parameter int IDX_W = 16,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic [PTR_W-1:0] head,
    input  logic [PTR_W:0]   count,
    input  logic [IDX_W-1:0] entry_idx [DEPTH],
    input  logic [IDX_W-1:0] lookup,
    output logic             hit,
    output logic [PTR_W-1:0] hit_idx
);

    // Walk from oldest to youngest; the last match seen wins.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (((PTR_W+1)'(k) < count) &&
                (entry_idx[head + PTR_W'(k)] == lookup)) begin
                hit     = 1'b1;
                hit_idx = head + PTR_W'(k);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/store_buffer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : store_buffer
// Brief  : Write-back store FIFO with load forwarding and idle-port draining.
// Rev    : 1.0
// ---------------------------------------------------------------------------
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int DEPTH = c_sb_depth,
    parameter int IDX_W = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [31:0]                cpu_address,
    input  logic [31:0]                cpu_write_data,
    input  logic                       cpu_mem_read,
    input  logic                       cpu_mem_write,
    output logic [31:0]                cpu_read_data,
    output logic                       stall,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic [31:0]                address,
    output logic [31:0]                write_data,
    output logic                       mem_read,
    output logic                       mem_write,
    input  logic [31:0]                read_data
);

    localparam int c_ptr_w = $clog2(DEPTH);

    sb_entry_t            r_entries [DEPTH];
    logic [c_ptr_w-1:0]   r_head;
    logic [c_ptr_w-1:0]   r_tail;
    logic [c_ptr_w:0]     r_count;

    logic [IDX_W-1:0]     w_entry_idx [DEPTH];
    logic                 w_hit;
    logic [c_ptr_w-1:0]   w_hit_idx;
    logic                 w_store;
    logic                 w_load;
    logic                 w_full;
    logic                 w_enq;
    logic                 w_miss;
    logic                 w_drain;

    generate
        for (genvar g = 0; g < DEPTH; g++) begin : g_entry_idx
            assign w_entry_idx[g] = r_entries[g].addr[IDX_W-1:0];
        end
    endgenerate

    store_buffer_match #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W),
        .PTR_W (c_ptr_w)
    ) u_match (
        .head      (r_head),
        .count     (r_count),
        .entry_idx (w_entry_idx),
        .lookup    (cpu_address[IDX_W-1:0]),
        .hit       (w_hit),
        .hit_idx   (w_hit_idx)
    );

    // Requests are masked while reset is held so every output is quiet at once.
    assign w_store = rst & cpu_mem_write;
    assign w_load  = rst & cpu_mem_read & ~cpu_mem_write;
    assign w_full  = (r_count == (c_ptr_w+1)'(DEPTH));
    assign w_enq   = w_store & ~w_full;
    assign w_miss  = w_load & ~w_hit;
    assign w_drain = rst & (r_count != '0) & ~w_miss;

    assign stall      = w_store & w_full;
    assign mem_read   = w_miss;
    assign mem_write  = w_drain;
    assign address    = w_miss  ? cpu_address :
                        w_drain ? r_entries[r_head].addr : c_word_zero;
    assign write_data = w_drain ? r_entries[r_head].data : c_word_zero;
    assign cpu_read_data = !w_load ? c_word_zero :
                           w_hit   ? r_entries[w_hit_idx].data : read_data;
    assign count = r_count;
    assign empty = (r_count == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_enq) begin
                r_tail <= r_tail + c_ptr_w'(1);
            end
            if (w_drain) begin
                r_head <= r_head + c_ptr_w'(1);
            end
            if (w_enq && !w_drain) begin
                r_count <= r_count + (c_ptr_w+1)'(1);
            end else if (!w_enq && w_drain) begin
                r_count <= r_count - (c_ptr_w+1)'(1);
            end
        end
    end

    // Payload storage needs no reset: only entries inside head..tail are read.
    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_entries[r_tail] <= '{addr: cpu_address, data: cpu_write_data};
        end
    end

endmodule
`default_nettype wire
